// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the core MEM stage and a debug/loader port, with starvation guard and debug lock.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_stall,
  output logic                  core_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_lock,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);
  typedef enum logic {ARB, LOCKED} state_t;
  typedef enum logic [1:0] {NONE, CORE, DBG} owner_t;
  state_t state;
  owner_t rd_owner;
  logic [CW-1:0] starve_cnt;
  logic core_req, core_gnt, dbg_win;
  // rd+wr together counts as a write, so core reads require ~core_wr
  always_comb begin
    core_req   = core_rd | core_wr;
    dbg_win    = ~reset & dbg_req & ((state == LOCKED) | ~core_req | (starve_cnt == LIM));
    core_gnt   = ~reset & core_req & (state == ARB) & ~dbg_win;
    core_stall = ~reset & core_req & ~core_gnt;
    dbg_gnt    = dbg_win;
    mem_rd     = dbg_win ? ~dbg_we : core_gnt & ~core_wr;
    mem_wr     = dbg_win ? dbg_we : core_gnt & core_wr;
    mem_addr   = dbg_win ? dbg_addr : core_gnt ? core_addr : '0;
    mem_wdata  = dbg_win ? dbg_wdata : core_gnt ? core_wdata : '0;
    mem_funct3 = dbg_win ? 3'b010 : core_gnt ? core_funct3 : 3'b000;
  end
  assign core_rvalid = rd_owner == CORE;
  assign dbg_rvalid  = rd_owner == DBG;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      rd_owner   <= NONE;
    end else begin
      state      <= (state == ARB) ? ((dbg_win & dbg_lock) ? LOCKED : ARB) : (dbg_lock ? LOCKED : ARB);
      starve_cnt <= (dbg_req & ~dbg_win) ? ((starve_cnt == LIM) ? starve_cnt : starve_cnt + CW'(1)) : '0;
      rd_owner   <= (dbg_win & ~dbg_we) ? DBG : (core_gnt & ~core_wr) ? CORE : NONE;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, stall, lock, starvation and read-return behaviour.
module tb_dmem_arbiter;
  logic clk = 0, reset = 1;
  logic core_rd = 0, core_wr = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [8:0] core_addr = 0, dbg_addr = 0;
  logic [31:0] core_wdata = 0, dbg_wdata = 0;
  logic [2:0] core_funct3 = 0;
  logic core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;
  logic [8:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0] mem_funct3;
  logic [31:0] mem [0:511];
  int passed = 0, total = 0;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_funct3(core_funct3), .core_stall(core_stall), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    core_rd = 0; core_wr = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
  endtask
  initial begin
    core_rd = 1; dbg_req = 1; core_addr = 9'h010; dbg_addr = 9'h020;
    #2;
    chk("rst_stall", core_stall, 0);
    chk("rst_gnt", dbg_gnt, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    idle();
    tick();
    reset = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hDEADBEEF;
    #1 chk("pre_gnt", dbg_gnt, 1);
    tick();
    idle(); core_rd = 1; core_addr = 9'h010; core_funct3 = 3'b010;
    #1;
    chk("core_stall", core_stall, 0);
    chk("core_mem_rd", mem_rd, 1);
    chk("core_mem_addr", mem_addr, 9'h010);
    tick();
    idle();
    chk("core_rvalid", core_rvalid, 1);
    chk("core_rdata", mem_rdata, 32'hDEADBEEF);
    chk("core_no_dbg_rv", dbg_rvalid, 0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
    #1;
    chk("dw_gnt", dbg_gnt, 1);
    chk("dw_mem_wr", mem_wr, 1);
    chk("dw_f3", mem_funct3, 3'b010);
    tick();
    dbg_we = 0;
    #1;
    chk("dr_gnt", dbg_gnt, 1);
    chk("dr_mem_rd", mem_rd, 1);
    chk("dr_f3", mem_funct3, 3'b010);
    tick();
    idle();
    chk("dr_rvalid", dbg_rvalid, 1);
    chk("dr_rdata", mem_rdata, 32'h12345678);
    chk("dr_no_core_rv", core_rvalid, 0);
    core_rd = 1; core_addr = 9'h010; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_gnt%0d", i), dbg_gnt, (i % 5) == 4);
      chk($sformatf("starve_stall%0d", i), core_stall, (i % 5) == 4);
      tick();
    end
    idle();
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 9'h030; dbg_wdata = 32'h1;
    #1 chk("lock_enter_gnt", dbg_gnt, 1);
    tick();
    core_wr = 1; core_addr = 9'h040; core_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 9'h031 + 9'(i);
      #1;
      chk($sformatf("lock_stall%0d", i), core_stall, 1);
      chk($sformatf("lock_gnt%0d", i), dbg_gnt, 1);
      tick();
    end
    dbg_req = 0; dbg_lock = 0;
    #1 chk("lock_last_stall", core_stall, 1);
    tick();
    #1;
    chk("unlock_stall", core_stall, 0);
    chk("unlock_mem_wr", mem_wr, 1);
    chk("unlock_addr", mem_addr, 9'h040);
    tick();
    idle();
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 9'h050;
    tick();
    dbg_we = 0; dbg_addr = 9'h020; core_rd = 1; core_addr = 9'h010;
    #1;
    chk("lkrd_gnt", dbg_gnt, 1);
    chk("lkrd_stall", core_stall, 1);
    #1 reset = 1;
    #1;
    chk("rst_lk_gnt", dbg_gnt, 0);
    chk("rst_lk_mem_rd", mem_rd, 0);
    chk("rst_lk_stall", core_stall, 0);
    tick();
    chk("rst_lk_rvalid", dbg_rvalid, 0);
    reset = 0;
    dbg_lock = 0;
    #1;
    chk("post_rst_stall", core_stall, 0);
    chk("post_rst_gnt", dbg_gnt, 0);
    tick();
    idle();
    chk("post_rst_dbg_rv", dbg_rvalid, 0);
    chk("post_rst_core_rv", core_rvalid, 1);
    core_rd = 1; core_wr = 1; core_addr = 9'h004; core_wdata = 32'hA5A5A5A5;
    #1;
    chk("rw_mem_wr", mem_wr, 1);
    chk("rw_mem_rd", mem_rd, 0);
    chk("rw_stall", core_stall, 0);
    tick();
    core_wr = 0;
    chk("rw_no_rvalid", core_rvalid, 0);
    tick();
    idle();
    chk("rw_readback_rv", core_rvalid, 1);
    chk("rw_readback", mem_rdata, 32'hA5A5A5A5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
